// File: rtl/cache_stage_skid.sv
// Cache-stage pipeline register with valid/ready handshake and 2-entry skid.
// Adds flush, occupancy report and a saturating backpressure stall counter.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   flush                : squash every held entry, drop same-cycle input
//   valid_in / ready_out : upstream handshake (ready_out from state flop)
//   tlb_result, destReg_addr_input, we_input, bp_input : incoming payload
//   valid_out / ready_in : downstream handshake
//   cache_result, destReg_addr_output, we_output, bp_output : head payload
//   occupancy            : entries held (0..2)
//   stall_cnt            : saturating count of valid_out & !ready_in cycles
module cache_stage_skid #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 3,
  parameter int BP_W        = 2,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [DATA_W-1:0]      tlb_result,
  input  logic [REG_AW-1:0]      destReg_addr_input,
  input  logic                   we_input,
  input  logic [BP_W-1:0]        bp_input,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [DATA_W-1:0]      cache_result,
  output logic [REG_AW-1:0]      destReg_addr_output,
  output logic                   we_output,
  output logic [BP_W-1:0]        bp_output,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dest;
    logic              we;
    logic [BP_W-1:0]   bp;
  } pl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE =
    {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  pl_t                    m_q, m_d;
  pl_t                    s_q, s_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  pl_t  in_pl;
  logic accept;
  logic drain;

  assign in_pl = {tlb_result, destReg_addr_input,
                  we_input, bp_input};

  assign ready_out = (state_q != FULL);
  assign valid_out = (state_q != EMPTY);

  // Input offered alongside a flush is dropped, never stored.
  assign accept = valid_in & ready_out & ~flush;
  assign drain  = valid_out & ready_in;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HALF;
          m_d     = in_pl;
        end
      end
      HALF: begin
        if (accept && drain) begin
          m_d = in_pl;
        end else if (accept) begin
          state_d = FULL;
          s_d     = in_pl;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = HALF;
          m_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Payload regs keep stale contents; only the state is squashed.
    if (flush) begin
      state_d = EMPTY;
    end

    if (valid_out && !ready_in && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cache_result        = m_q.data;
  assign destReg_addr_output = m_q.dest;
  assign we_output           = m_q.we & valid_out;
  assign bp_output           = m_q.bp;
  assign occupancy           = state_q;
  assign stall_cnt           = cnt_q;

endmodule

// File: tb/tb_cache_stage_skid.sv
// Bench for cache_stage_skid: scoreboard of accepted payloads
// checked in FIFO order against drained outputs, plus scenario checks.
module tb_cache_stage_skid;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int BW = 2;
  localparam int CW = 4;
  localparam int PW = DW + AW + 1 + BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] tlb_result;
  logic [AW-1:0] dest_in;
  logic          we_in;
  logic [BW-1:0] bp_in;
  logic          valid_out;
  logic          ready_in;
  logic [DW-1:0] cache_result;
  logic [AW-1:0] dest_out;
  logic          we_out;
  logic [BW-1:0] bp_out;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] sb[$];

  cache_stage_skid #(
    .DATA_W(DW), .REG_AW(AW), .BP_W(BW), .STALL_CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .tlb_result(tlb_result),
    .destReg_addr_input(dest_in),
    .we_input(we_in),
    .bp_input(bp_in),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .cache_result(cache_result),
    .destReg_addr_output(dest_out),
    .we_output(we_out),
    .bp_output(bp_out),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs are stable here; they take effect at next posedge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (valid_out && ready_in) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, required no output",
                   cache_result);
        end else begin
          logic [PW-1:0] exp;
          exp = sb.pop_front();
          if ({cache_result, dest_out, we_out, bp_out} !== exp) begin
            errors++;
            $display("FAIL sb_order: got %h, required %h",
                     {cache_result, dest_out, we_out, bp_out}, exp);
          end
        end
      end
      if (flush) sb.delete();
      else if (valid_in && ready_out)
        sb.push_back({tlb_result, dest_in, we_in, bp_in});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic [AW-1:0] a, input logic w,
                       input logic [BW-1:0] b);
    valid_in   = v;
    tlb_result = d;
    dest_in    = a;
    we_in      = w;
    bp_in      = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ready_in = 1'b0;
    drive(1'b1, 16'h5555, 3'd7, 1'b1, 2'd3);
    tick();
    tick();
    checks++;
    if ({valid_out, we_out, cache_result, occupancy,
         ready_out, stall_cnt} !== {1'b0, 1'b0, 16'h0, 2'd0,
         1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b we=%b d=%h occ=%0d rdy=%b st=%0d, required 0 0 0000 0 1 0",
               valid_out, we_out, cache_result, occupancy,
               ready_out, stall_cnt);
    end
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
  endtask

  task automatic test_stream();
    logic [DW-1:0] vals[4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], AW'(i), 1'b1, BW'(i));
      tick();
      checks++;
      if (!valid_out || cache_result !== vals[i] ||
          !ready_out || occupancy > 2'd1 || we_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b d=%h rdy=%b occ=%0d we=%b, required 1 %h 1 <=1 1",
                 i, valid_out, cache_result, ready_out,
                 occupancy, we_out, vals[i]);
      end
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    checks++;
    if (valid_out !== 1'b0 || we_out !== 1'b0) begin
      errors++;
      $display("FAIL stream_empty: got v=%b we=%b, required 0 0",
               valid_out, we_out);
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    drive(1'b1, 16'hAAAA, 3'd1, 1'b1, 2'd1);
    tick();
    drive(1'b1, 16'hBBBB, 3'd2, 1'b0, 2'd2);
    tick();
    drive(1'b1, 16'hCCCC, 3'd3, 1'b1, 2'd3);
    tick();
    checks++;
    if (occupancy !== 2'd2 || ready_out !== 1'b0 ||
        cache_result !== 16'hAAAA) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d rdy=%b d=%h, required 2 0 aaaa",
               occupancy, ready_out, cache_result);
    end
    ready_in = 1'b1;
    tick();
    checks++;
    if (!valid_out || cache_result !== 16'hBBBB ||
        we_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: got v=%b d=%h we=%b, required 1 bbbb 0",
               valid_out, cache_result, we_out);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (!valid_out || cache_result !== 16'hCCCC) begin
      errors++;
      $display("FAIL bp_third: got v=%b d=%h, required 1 cccc",
               valid_out, cache_result);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bp_drained: got v=%b occ=%0d, required 0 0",
               valid_out, occupancy);
    end
  endtask

  task automatic test_flush();
    ready_in = 1'b0;
    drive(1'b1, 16'h1234, 3'd4, 1'b1, 2'd0);
    tick();
    drive(1'b1, 16'h5678, 3'd5, 1'b1, 2'd1);
    tick();
    flush = 1'b1;
    drive(1'b1, 16'hDDDD, 3'd6, 1'b1, 2'd2);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    checks++;
    if ({valid_out, we_out, occupancy, ready_out} !==
        {1'b0, 1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush_state: got v=%b we=%b occ=%0d rdy=%b, required 0 0 0 1",
               valid_out, we_out, occupancy, ready_out);
    end
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak: got v=%b d=%h, required v=0",
                 valid_out, cache_result);
      end
    end
  endtask

  task automatic test_stall_sat();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready_in = 1'b0;
    drive(1'b1, 16'h0F0F, 3'd2, 1'b1, 2'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) begin
        checks++;
        if (stall_cnt !== 4'd14) begin
          errors++;
          $display("FAIL stall_14: got %0d, required 14", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat: got %0d, required 15", stall_cnt);
    end
    tick();
    tick();
    tick();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_hold: got %0d, required 15", stall_cnt);
    end
    ready_in = 1'b1;
    tick();
  endtask

  task automatic test_reset_full();
    ready_in = 1'b0;
    drive(1'b1, 16'h9999, 3'b101, 1'b1, 2'd2);
    tick();
    drive(1'b1, 16'h7777, 3'b101, 1'b1, 2'd3);
    tick();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL rst_full_pre: got occ=%0d, required 2", occupancy);
    end
    reset = 1'b1;
    drive(1'b1, 16'h6666, 3'b111, 1'b1, 2'd1);
    tick();
    checks++;
    if ({valid_out, we_out, cache_result, dest_out, bp_out,
         occupancy, stall_cnt, ready_out} !==
        {1'b0, 1'b0, 16'h0, 3'd0, 2'd0, 2'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_full: got v=%b we=%b d=%h a=%0d bp=%0d occ=%0d st=%0d rdy=%b, required all 0, rdy=1",
               valid_out, we_out, cache_result, dest_out, bp_out,
               occupancy, stall_cnt, ready_out);
    end
    reset = 1'b0;
    ready_in = 1'b1;
    drive(1'b1, 16'h4242, 3'd3, 1'b1, 2'd2);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (!valid_out || cache_result !== 16'h4242 ||
        dest_out !== 3'd3 || we_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_push: got v=%b d=%h a=%0d we=%b, required 1 4242 3 1",
               valid_out, cache_result, dest_out, we_out);
    end
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries, required 0",
               sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
